bids_n_arbiter: RTL and testbench
=================================

# bids_n_arbiter

Parametrised N-bidder sealed-bid auction controller, the successor to the fixed three-bidder `bids22` engine. A controller port configures balances, mask, round timer and per-bid charge while unlocked. Bidders then bid and retract during timed rounds while locked. The block resolves the round and debits the winner. It sits between the host command interface and the per-bidder request ports.

## Interface
- `N`, 3: bidder count, 2..32.
- `AMT_W`, 16: bid amount width.
- `BAL_W`, 32: balance width; must be at least `AMT_W`.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `bid`  in  N  per-bidder bid request, one cycle per request.
- `bid_amt`  in  N×AMT_W  bid amount, sampled with `bid`.
- `retract`  in  N  per-bidder retract request.
- `c_start`  in  1  round active level.
- `c_op`  in  4  controller opcode.
- `c_data`  in  32  controller operand.
- `ack`  out  N  request accepted, one-cycle pulse.
- `bidder_err`  out  N×2  per-bidder error, one-cycle pulse.
- `win`  out  N  winner flag, one-hot or zero.
- `balance`  out  N×BAL_W  current balances.
- `max_bid`  out  AMT_W  winning amount.
- `ready`  out  1  block accepts commands.
- `round_over`  out  1  round-resolution pulse.
- `err`  out  3  controller error, one-cycle pulse.

## Operation
- **States:** UNLOCKED, LOCKED, ROUND, RESULT. Reset enters UNLOCKED.
- **Reset values:** key 0, mask all ones, timer 0xF, cost 1, selected bidder 0, all current bids 0. All outputs 0.
- **Opcodes:**
  - 0 NoOp
  - 1 Unlock
  - 2 Lock: key←c_data, go to LOCKED
  - 3 SelectBidder: sel←c_data modulo N
  - 4 LoadBalance: balance[sel]←c_data
  - 5 SetMask: c_data[N-1:0]
  - 6 SetTimer
  - 7 BidCharge
  - 8–15 invalid
- **Controller errors (`err`):**
  - 001 bad key
  - 010 already unlocked
  - 011 `c_start` while UNLOCKED
  - 100 invalid opcode or opcode not allowed in the current state
  - 101 tie
- **UNLOCKED:** opcodes 0 and 2–7 are legal; opcode 1 raises 010. `c_start`=1 raises 011 every cycle it is high. A rejected command has no side effect.
- **LOCKED:**
  - Unlock with c_data==key goes to UNLOCKED; a mismatched key raises 001 and the state stays LOCKED.
  - Opcodes 2–7 raise 100.
  - A `c_start` rising edge loads the countdown from timer and enters ROUND.
- **ROUND:**
  - The countdown decrements every cycle.
  - ROUND exits to RESULT when `c_start` falls or the countdown reaches 0, whichever comes first.
  - Any nonzero opcode raises 100.
- **Bid i in ROUND:**
  - mask[i]=0: `bidder_err` 11.
  - Otherwise, balance[i] < amt+cost: `bidder_err` 10, and cost is debited when balance ≥ cost.
  - Otherwise: cur[i]←amt, balance[i]−=cost, `ack`.
  - A repeat bid overwrites the previous one.
- **Retract i in ROUND:** cur[i]←0, `ack`, no refund.
- **Bid and retract together:** the bid is processed and the retract is ignored.
- **Outside ROUND:** `bid` or `retract` gives `bidder_err` 01.
- **RESULT (one cycle):**
  - Find the highest nonzero cur. If it is unique: win[i]=1, max_bid=cur[i], balance[i]−=cur[i].
  - If the highest value is shared: `err` 101, no winner, max_bid=0.
  - If all cur are 0: no winner, max_bid=0.
  - `round_over` pulses. All cur clear. The state returns to LOCKED.
- `win` and `max_bid` hold until the next `c_start` rising edge.
- Arithmetic is unsigned, and amt+cost is evaluated at BAL_W+1 bits so it cannot overflow.

## Timing
- All outputs are registered. `ack`, `bidder_err` and `err` appear the cycle after the request is sampled.
- `ready` is 0 in reset and 1 from the first edge after `reset_n` deasserts.
- `round_over` and `win` assert one cycle after the ROUND exit condition.
- A bid sampled on the same edge that ROUND exits is still processed as in-round.
- Timer 0: ROUND lasts one cycle.
- Asserting `reset_n` mid-round immediately clears all state, balances and outputs, with no resolution.

## Structure
- Package `bids_pkg` holds:
  - the `c_op` enum
  - the controller error codes
  - the bidder error codes
  - the state enum
- Sub-module `bid_channel` holds one bidder's balance, current bid, ack/err and debit logic. It is instantiated N times via generate.
- The top level holds the FSM, countdown, config registers and the max/tie reduction.

## Test plan
- **Configure and lock:** reset; SelectBidder 1, LoadBalance 100, Lock 0xAB; Unlock 0x12 → `err` 001, still locked; Unlock 0xAB → UNLOCKED; Unlock again → `err` 010.
- **Unique winner:** N=3, all balances 100, cost 1. In ROUND bids 10/40/20 → 3 `ack` pulses. At round end: win=010, max_bid=40, balances 99/59/99.
- **Tie:** bids 30/30/5 → `err` 101, win=0, max_bid=0, balances each reduced by cost only.
- **Per-bidder errors:** with mask=110, bidder 0 bids → `bidder_err` 11. Balance 5 with bid 5 and cost 1 → `bidder_err` 10, balance 4. A bid while LOCKED with `c_start`=0 → `bidder_err` 01.
- **Timer expiry:** SetTimer 3, `c_start` held high → `round_over` after 4 ROUND cycles. Bidder 2 bid 50 then retract → no winner.
- **Reset mid-round:** pull `reset_n` low mid-round → all outputs 0 asynchronously; after release, state UNLOCKED and mask all ones.

Source files
------------

// File: rtl/bids_pkg.sv
// rtl/bids_pkg.sv - shared opcode, error-code and state definitions for the auction controller
package bids_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_UNLOCK     = 4'd1,
        OP_LOCK       = 4'd2,
        OP_SEL        = 4'd3,
        OP_LOAD_BAL   = 4'd4,
        OP_SET_MASK   = 4'd5,
        OP_SET_TIMER  = 4'd6,
        OP_BID_CHARGE = 4'd7
    } c_op_e;

    typedef enum logic [2:0] {
        CERR_NONE     = 3'd0,
        CERR_BAD_KEY  = 3'd1,
        CERR_UNLOCKED = 3'd2,
        CERR_START    = 3'd3,
        CERR_BAD_OP   = 3'd4,
        CERR_TIE      = 3'd5
    } c_err_e;

    typedef enum logic [1:0] {
        BERR_NONE    = 2'd0,
        BERR_OUTSIDE = 2'd1,
        BERR_FUNDS   = 2'd2,
        BERR_MASKED  = 2'd3
    } b_err_e;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_ROUND,
        ST_RESULT
    } state_e;

    localparam int                 TIMER_W   = 16;
    localparam logic [TIMER_W-1:0] TIMER_RST = 16'hF;

endpackage

// File: rtl/bid_channel.sv
// rtl/bid_channel.sv - one bidder: balance, current bid, request acknowledge/error and debits
module bid_channel
    import bids_pkg::*;
#(
    parameter int AMT_W = 16,
    parameter int BAL_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_round,
    input  logic             clear,
    input  logic             debit_win,
    input  logic             load,
    input  logic [BAL_W-1:0] load_val,
    input  logic [BAL_W-1:0] cost,
    input  logic             mask,
    input  logic             bid,
    input  logic [AMT_W-1:0] amt,
    input  logic             retract,
    output logic             ack,
    output logic [1:0]       err,
    output logic [BAL_W-1:0] balance,
    output logic [AMT_W-1:0] cur
);

    // One extra bit so amt + cost never wraps
    logic [BAL_W:0] need;
    logic           affordable;

    assign need       = (BAL_W+1)'(amt) + (BAL_W+1)'(cost);
    assign affordable = {1'b0, balance} >= need;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack     <= 1'b0;
            err     <= BERR_NONE;
            balance <= '0;
            cur     <= '0;
        end else begin
            ack <= 1'b0;
            err <= BERR_NONE;
            if (load) begin
                balance <= load_val;
            end
            if (clear) begin
                cur <= '0;
                if (debit_win) begin
                    balance <= balance - BAL_W'(cur);
                end
            end
            if (bid || retract) begin
                if (!in_round) begin
                    err <= BERR_OUTSIDE;
                end else if (bid) begin
                    if (!mask) begin
                        err <= BERR_MASKED;
                    end else if (!affordable) begin
                        err <= BERR_FUNDS;
                        if (balance >= cost) begin
                            balance <= balance - cost;
                        end
                    end else begin
                        cur     <= amt;
                        balance <= balance - cost;
                        ack     <= 1'b1;
                    end
                end else begin
                    cur <= '0;
                    ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bids_n_arbiter.sv
// rtl/bids_n_arbiter.sv - N-bidder sealed-bid auction controller: FSM, config registers, round timer, max/tie resolution
module bids_n_arbiter
    import bids_pkg::*;
#(
    parameter int N     = 3,
    parameter int AMT_W = 16,
    parameter int BAL_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       bid,
    input  logic [N*AMT_W-1:0] bid_amt,
    input  logic [N-1:0]       retract,
    input  logic               c_start,
    input  logic [3:0]         c_op,
    input  logic [31:0]        c_data,
    output logic [N-1:0]       ack,
    output logic [2*N-1:0]     bidder_err,
    output logic [N-1:0]       win,
    output logic [N*BAL_W-1:0] balance,
    output logic [AMT_W-1:0]   max_bid,
    output logic               ready,
    output logic               round_over,
    output logic [2:0]         err
);

    localparam int SEL_W = $clog2(N);

    state_e             state, state_d;
    logic [31:0]        key;
    logic [N-1:0]       mask;
    logic [TIMER_W-1:0] timer, cnt;
    logic [BAL_W-1:0]   cost;
    logic [SEL_W-1:0]   sel;
    logic               c_start_q, start_rise, cfg_we;
    logic [2:0]         err_d;
    logic [AMT_W-1:0]   cur [N];
    logic [AMT_W-1:0]   max_v;
    logic               tie;
    logic [N-1:0]       win_d;

    assign start_rise = c_start & ~c_start_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_UNLOCKED;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_UNLOCKED: if (c_op == OP_LOCK) state_d = ST_LOCKED;
            ST_LOCKED: begin
                if (c_op == OP_UNLOCK && c_data == key) state_d = ST_UNLOCKED;
                else if (start_rise)                    state_d = ST_ROUND;
            end
            ST_ROUND:  if (!c_start || cnt == '0) state_d = ST_RESULT;
            ST_RESULT: state_d = ST_LOCKED;
            default:   state_d = ST_UNLOCKED;
        endcase
    end

    // Command legality and controller error; a legal UNLOCKED command still executes under c_start
    always_comb begin
        err_d  = CERR_NONE;
        cfg_we = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (c_op == OP_UNLOCK)  err_d = CERR_UNLOCKED;
                else if (c_op[3])       err_d = CERR_BAD_OP;
                else begin
                    cfg_we = 1'b1;
                    if (c_start) err_d = CERR_START;
                end
            end
            ST_LOCKED: begin
                if (c_op == OP_UNLOCK && c_data != key) err_d = CERR_BAD_KEY;
                else if (c_op >= 4'd2)                  err_d = CERR_BAD_OP;
            end
            ST_ROUND:  if (c_op != OP_NOP) err_d = CERR_BAD_OP;
            ST_RESULT: begin
                if (tie)                   err_d = CERR_TIE;
                else if (c_op != OP_NOP)   err_d = CERR_BAD_OP;
            end
            default: err_d = CERR_NONE;
        endcase
    end

    // A strictly larger bid clears any tie seen so far among smaller values
    always_comb begin
        max_v = '0;
        tie   = 1'b0;
        win_d = '0;
        for (int i = 0; i < N; i++) begin
            if (cur[i] > max_v) begin
                max_v = cur[i];
                tie   = 1'b0;
            end else if (cur[i] == max_v && cur[i] != '0) begin
                tie = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            win_d[i] = !tie && (max_v != '0) && (cur[i] == max_v);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key        <= '0;
            mask       <= '1;
            timer      <= TIMER_RST;
            cost       <= BAL_W'(1);
            sel        <= '0;
            cnt        <= '0;
            c_start_q  <= 1'b0;
            win        <= '0;
            max_bid    <= '0;
            ready      <= 1'b0;
            round_over <= 1'b0;
            err        <= CERR_NONE;
        end else begin
            ready      <= 1'b1;
            c_start_q  <= c_start;
            err        <= err_d;
            round_over <= (state == ST_RESULT);
            if (cfg_we) begin
                case (c_op)
                    OP_LOCK:       key   <= c_data;
                    OP_SEL:        sel   <= SEL_W'(c_data % 32'(N));
                    OP_SET_MASK:   mask  <= c_data[N-1:0];
                    OP_SET_TIMER:  timer <= c_data[TIMER_W-1:0];
                    OP_BID_CHARGE: cost  <= BAL_W'(c_data);
                    default:       ;
                endcase
            end
            if (state == ST_LOCKED && state_d == ST_ROUND) begin
                cnt     <= timer;
                win     <= '0;
                max_bid <= '0;
            end else if (state == ST_ROUND && cnt != '0) begin
                cnt <= cnt - TIMER_W'(1);
            end
            if (state == ST_RESULT) begin
                win     <= win_d;
                max_bid <= tie ? '0 : max_v;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        bid_channel #(
            .AMT_W(AMT_W),
            .BAL_W(BAL_W)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_round (state == ST_ROUND),
            .clear    (state == ST_RESULT),
            .debit_win(win_d[i]),
            .load     (cfg_we && c_op == OP_LOAD_BAL && sel == SEL_W'(i)),
            .load_val (BAL_W'(c_data)),
            .cost     (cost),
            .mask     (mask[i]),
            .bid      (bid[i]),
            .amt      (bid_amt[i*AMT_W +: AMT_W]),
            .retract  (retract[i]),
            .ack      (ack[i]),
            .err      (bidder_err[2*i +: 2]),
            .balance  (balance[i*BAL_W +: BAL_W]),
            .cur      (cur[i])
        );
    end

endmodule

// File: tb/tb_bids_n_arbiter.sv
// tb/tb_bids_n_arbiter.sv - self-checking bench for bids_n_arbiter
module tb_bids_n_arbiter;

    localparam int N = 3, AMT_W = 16, BAL_W = 32;
    localparam logic [31:0] KEY = 32'h5A;

    logic               clk = 1'b0, reset_n = 1'b0;
    logic [N-1:0]       bid = '0, retract = '0;
    logic [N*AMT_W-1:0] bid_amt = '0;
    logic               c_start = 1'b0;
    logic [3:0]         c_op = '0;
    logic [31:0]        c_data = '0;
    logic [N-1:0]       ack, win;
    logic [2*N-1:0]     bidder_err;
    logic [N*BAL_W-1:0] balance;
    logic [AMT_W-1:0]   max_bid;
    logic               ready, round_over;
    logic [2:0]         err;

    bids_n_arbiter #(.N(N), .AMT_W(AMT_W), .BAL_W(BAL_W)) dut (
        .clk(clk), .reset_n(reset_n), .bid(bid), .bid_amt(bid_amt), .retract(retract),
        .c_start(c_start), .c_op(c_op), .c_data(c_data), .ack(ack), .bidder_err(bidder_err),
        .win(win), .balance(balance), .max_bid(max_bid), .ready(ready),
        .round_over(round_over), .err(err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] data;
        logic        start;
        logic [2:0]  exp_err;
    } vec_t;
    vec_t vecs[12];

    // Reference model state
    int m_bal[N], m_cur[N], m_mask[N], m_cost;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [63:0] bal(input int i);
        return 64'(balance[i*BAL_W +: BAL_W]);
    endfunction

    function automatic logic [63:0] berr(input int i);
        return 64'(bidder_err[2*i +: 2]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [31:0] data);
        c_op = op;
        c_data = data;
        step();
        c_op = '0;
        c_data = '0;
    endtask

    task automatic set_amt(input int i, input int a);
        bid_amt[i*AMT_W +: AMT_W] = AMT_W'(a);
    endtask

    task automatic setup(input int msk, input int cst, input int b0, input int b1, input int b2, input int tmr);
        int b[3];
        b = '{b0, b1, b2};
        cmd(4'd5, 32'(msk)); check("setup_mask_err", 64'(err), 64'd0);
        cmd(4'd7, 32'(cst)); check("setup_cost_err", 64'(err), 64'd0);
        cmd(4'd6, 32'(tmr));
        for (int i = 0; i < N; i++) begin
            cmd(4'd3, 32'(i));
            cmd(4'd4, 32'(b[i]));
        end
        cmd(4'd2, KEY); check("setup_lock_err", 64'(err), 64'd0);
    endtask

    task automatic start_round();
        c_start = 1'b1;
        step();
    endtask

    task automatic end_round();
        bid = '0;
        retract = '0;
        c_start = 1'b0;
        step();
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int waited, mx, cnt, widx, r, a;
        logic [N-1:0] exp_ack;
        int exp_berr[N];

        vecs[0]  = '{4'd3,  32'd1,   1'b0, 3'd0};
        vecs[1]  = '{4'd4,  32'd100, 1'b0, 3'd0};
        vecs[2]  = '{4'd2,  32'hAB,  1'b0, 3'd0};
        vecs[3]  = '{4'd1,  32'h12,  1'b0, 3'd1};
        vecs[4]  = '{4'd6,  32'd5,   1'b0, 3'd4};
        vecs[5]  = '{4'd9,  32'd0,   1'b0, 3'd4};
        vecs[6]  = '{4'd0,  32'd0,   1'b0, 3'd0};
        vecs[7]  = '{4'd1,  32'hAB,  1'b0, 3'd0};
        vecs[8]  = '{4'd1,  32'd0,   1'b0, 3'd2};
        vecs[9]  = '{4'd0,  32'd0,   1'b1, 3'd3};
        vecs[10] = '{4'd12, 32'd0,   1'b0, 3'd4};
        vecs[11] = '{4'd7,  32'd1,   1'b0, 3'd0};

        // Reset state
        repeat (3) step();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_win", 64'(win), 64'd0);
        check("rst_balance", 64'(balance[63:0]), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_max_bid", 64'(max_bid), 64'd0);
        reset_n = 1'b1;
        step();
        check("ready_after_reset", 64'(ready), 64'd1);

        // Configure and lock, table driven
        for (int k = 0; k < 12; k++) begin
            c_op = vecs[k].op;
            c_data = vecs[k].data;
            c_start = vecs[k].start;
            step();
            check($sformatf("vec%0d_err", k), 64'(err), 64'(vecs[k].exp_err));
        end
        c_op = '0; c_data = '0; c_start = 1'b0;
        step();
        check("vec_balance1", bal(1), 64'd100);

        // Unique winner
        setup(7, 1, 100, 100, 100, 20);
        start_round();
        bid = 3'b111; set_amt(0, 10); set_amt(1, 40); set_amt(2, 20);
        step();
        check("uniq_ack", 64'(ack), 64'b111);
        end_round();
        check("uniq_round_over", 64'(round_over), 64'd1);
        check("uniq_win", 64'(win), 64'b010);
        check("uniq_max_bid", 64'(max_bid), 64'd40);
        check("uniq_bal0", bal(0), 64'd99);
        check("uniq_bal1", bal(1), 64'd59);
        check("uniq_bal2", bal(2), 64'd99);
        step();
        check("uniq_win_hold", 64'(win), 64'b010);
        check("uniq_round_over_pulse", 64'(round_over), 64'd0);

        // Tie
        start_round();
        check("tie_win_cleared", 64'(win), 64'd0);
        bid = 3'b111; set_amt(0, 30); set_amt(1, 30); set_amt(2, 5);
        step();
        check("tie_ack", 64'(ack), 64'b111);
        end_round();
        check("tie_err", 64'(err), 64'd5);
        check("tie_win", 64'(win), 64'd0);
        check("tie_max_bid", 64'(max_bid), 64'd0);
        check("tie_bal0", bal(0), 64'd98);
        check("tie_bal1", bal(1), 64'd58);
        check("tie_bal2", bal(2), 64'd98);

        // Per-bidder errors
        bid = 3'b001; set_amt(0, 1);
        step();
        bid = '0;
        check("locked_bid_berr", berr(0), 64'd1);
        check("locked_bid_ack", 64'(ack), 64'd0);
        cmd(4'd1, KEY);
        check("unlock_err", 64'(err), 64'd0);
        setup(6, 1, 100, 100, 5, 20);
        start_round();
        bid = 3'b101; set_amt(0, 10); set_amt(2, 5);
        step();
        check("masked_berr", berr(0), 64'd3);
        check("funds_berr", berr(2), 64'd2);
        check("funds_ack", 64'(ack), 64'd0);
        check("funds_bal2", bal(2), 64'd4);
        end_round();
        check("errs_round_over", 64'(round_over), 64'd1);
        check("errs_win", 64'(win), 64'd0);

        // Timer expiry with c_start held high
        cmd(4'd1, KEY);
        setup(7, 1, 100, 100, 100, 3);
        start_round();
        bid = 3'b100; set_amt(2, 50);
        step();
        check("timer_bid_ack", 64'(ack), 64'b100);
        bid = '0; retract = 3'b100;
        step();
        check("timer_retract_ack", 64'(ack), 64'b100);
        retract = '0;
        waited = 2;
        while (!round_over && waited < 20) begin
            step();
            waited++;
        end
        check("timer_cycles", 64'(waited), 64'd5);
        check("timer_win", 64'(win), 64'd0);
        check("timer_max_bid", 64'(max_bid), 64'd0);
        check("timer_bal2", bal(2), 64'd99);
        c_start = 1'b0;
        step();

        // Randomised rounds against the model
        for (int rnd = 0; rnd < 25; rnd++) begin
            cmd(4'd1, KEY);
            check("rnd_unlock_err", 64'(err), 64'd0);
            r = int'($urandom_range(0, 7));
            m_cost = int'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                m_mask[i] = (r >> i) & 1;
                m_bal[i] = int'($urandom_range(0, 120));
                m_cur[i] = 0;
            end
            setup(r, m_cost, m_bal[0], m_bal[1], m_bal[2], 50);
            start_round();
            for (int c = 0, len = int'($urandom_range(1, 6)); c < len; c++) begin
                exp_ack = '0;
                for (int i = 0; i < N; i++) begin
                    r = int'($urandom_range(0, 3));
                    a = 10 * int'($urandom_range(0, 5));
                    bid[i] = (r == 1 || r == 3);
                    retract[i] = (r == 2 || r == 3);
                    set_amt(i, a);
                    exp_berr[i] = 0;
                    if (bid[i]) begin
                        if (m_mask[i] == 0) exp_berr[i] = 3;
                        else if (m_bal[i] < a + m_cost) begin
                            exp_berr[i] = 2;
                            if (m_bal[i] >= m_cost) m_bal[i] -= m_cost;
                        end else begin
                            m_cur[i] = a;
                            m_bal[i] -= m_cost;
                            exp_ack[i] = 1'b1;
                        end
                    end else if (retract[i]) begin
                        m_cur[i] = 0;
                        exp_ack[i] = 1'b1;
                    end
                end
                step();
                check("rnd_ack", 64'(ack), 64'(exp_ack));
                for (int i = 0; i < N; i++) check($sformatf("rnd_berr%0d", i), berr(i), 64'(exp_berr[i]));
            end
            end_round();
            mx = 0;
            for (int i = 0; i < N; i++) if (m_cur[i] > mx) mx = m_cur[i];
            cnt = 0;
            widx = -1;
            for (int i = 0; i < N; i++) if (mx > 0 && m_cur[i] == mx) begin cnt++; widx = i; end
            if (cnt == 1) m_bal[widx] -= mx;
            check("rnd_round_over", 64'(round_over), 64'd1);
            check("rnd_win", 64'(win), (cnt == 1) ? (64'd1 << widx) : 64'd0);
            check("rnd_max_bid", 64'(max_bid), (cnt == 1) ? 64'(mx) : 64'd0);
            check("rnd_err", 64'(err), (cnt > 1) ? 64'd5 : 64'd0);
            for (int i = 0; i < N; i++) check($sformatf("rnd_bal%0d", i), bal(i), 64'(m_bal[i]));
        end

        // Reset mid-round
        cmd(4'd1, KEY);
        setup(7, 1, 50, 50, 50, 30);
        start_round();
        bid = 3'b001; set_amt(0, 5);
        step();
        check("pre_reset_ack", 64'(ack), 64'b001);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ack", 64'(ack), 64'd0);
        check("async_rst_balance", 64'(balance[63:0]), 64'd0);
        check("async_rst_ready", 64'(ready), 64'd0);
        bid = '0;
        c_start = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("post_reset_ready", 64'(ready), 64'd1);
        cmd(4'd6, 32'd8);
        check("post_reset_unlocked", 64'(err), 64'd0);
        cmd(4'd3, 32'd0);
        cmd(4'd4, 32'd20);
        cmd(4'd2, KEY);
        start_round();
        bid = 3'b001; set_amt(0, 3);
        step();
        check("post_reset_mask_ack", 64'(ack), 64'b001);
        check("post_reset_mask_berr", berr(0), 64'd0);
        end_round();
        check("post_reset_win", 64'(win), 64'b001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
